// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port RAM arbiter between the instruction and data paths.
//               Data wins by default; a streak counter guards instruction fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_error
);

    // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
    localparam logic [1:0] c_ACCESS       = 2'd2;
    localparam logic [1:0] c_ERROR        = 2'd3;
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IGNT  = 2'd1,
        DGNT  = 2'd2,
        RECOV = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_streak;
    logic [3:0]  w_streak_next;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic        r_wr;
    logic        r_ram_error;

    logic        w_ireq;
    logic        w_dreq;
    logic        w_latch_i;
    logic        w_latch_d;
    logic        w_set_err;

    assign w_ireq    = iREN;
    assign w_dreq    = dREN | dWEN;
    assign ramaddr   = r_addr;
    assign ramstore  = r_store;
    assign ram_error = r_ram_error;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_streak    <= 4'd0;
            r_addr      <= 32'd0;
            r_store     <= 32'd0;
            r_wr        <= 1'b0;
            r_ram_error <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_streak <= w_streak_next;
            if (w_latch_d) begin
                r_addr  <= daddr;
                r_store <= dstore;
                r_wr    <= dWEN;
            end else if (w_latch_i) begin
                r_addr <= iaddr;
                r_wr   <= 1'b0;
            end
            if (w_set_err) begin
                r_ram_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_streak_next = r_streak;
        w_latch_i     = 1'b0;
        w_latch_d     = 1'b0;
        w_set_err     = 1'b0;
        iwait         = 1'b1;
        dwait         = 1'b1;
        iload         = 32'd0;
        dload         = 32'd0;
        ramREN        = 1'b0;
        ramWEN        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_dreq && (!w_ireq || r_streak != c_STARVE_LIMIT)) begin
                    w_next    = DGNT;
                    w_latch_d = 1'b1;
                end else if (w_ireq) begin
                    w_next    = IGNT;
                    w_latch_i = 1'b1;
                end
            end

            IGNT: begin
                ramREN = 1'b1;
                if (ramstate == c_ACCESS) begin
                    iwait         = 1'b0;
                    iload         = ramload;
                    w_streak_next = 4'd0;
                    w_next        = RECOV;
                end else begin
                    // FREE and BUSY both mean keep waiting
                    if (ramstate == c_ERROR) begin
                        w_set_err = 1'b1;
                        w_next    = RECOV;
                    end
                    if (!w_ireq) begin
                        ramREN = 1'b0;
                        w_next = RECOV;
                    end
                end
            end

            DGNT: begin
                ramREN = ~r_wr;
                ramWEN = r_wr;
                if (ramstate == c_ACCESS) begin
                    dwait  = 1'b0;
                    dload  = ramload;
                    w_next = RECOV;
                    if (iREN && r_streak < c_STARVE_LIMIT) begin
                        w_streak_next = r_streak + 4'd1;
                    end
                end else begin
                    if (ramstate == c_ERROR) begin
                        w_set_err = 1'b1;
                        w_next    = RECOV;
                    end
                    if (!w_dreq) begin
                        ramREN = 1'b0;
                        ramWEN = 1'b0;
                        w_next = RECOV;
                    end
                end
            end

            // Caches drop their request one cycle after wait=0; skip that cycle
            RECOV: begin
                w_next = IDLE;
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
